// File: rtl/boot_loader_ctrl.sv
// Boot loader sequencer: streams decoded UART words into instruction memory while holding the core in reset.
// Optional checksum accumulator enabled by defining BOOT_LOADER_CHECKSUM_EN.
module boot_loader_ctrl #(
  parameter int MEM_WORDS      = 1024,
  parameter int ADDR_W         = 10,
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int RELEASE_DELAY  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              word_valid,
  input  logic [31:0]       instruction_word,
  input  logic [31:0]       byte_address,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              load_done,
  output logic              addr_error,
  output logic [15:0]       word_count,
  output logic [31:0]       checksum
);

  localparam int          IDLE_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam int          HOLD_W     = (RELEASE_DELAY > 1) ? $clog2(RELEASE_DELAY) : 1;
  localparam logic [31:0] ADDR_LIMIT = 32'(MEM_WORDS * 4);

  typedef enum logic [1:0] {IDLE, LOAD, HOLD, RUN} state_t;

  state_t            state, state_nxt;
  logic [IDLE_W-1:0] idle_cnt;
  logic [HOLD_W-1:0] hold_cnt;

  logic vld_p0, term_p0, accept_p0, reject_p0, start_p0, timeout_p0, hold_done_p0;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Stage p0: classify the incoming word and the timers
  always_comb begin
    vld_p0       = word_valid;
    term_p0      = (instruction_word == 32'hFFFF_FFFF);
    accept_p0    = vld_p0 && !term_p0 && (byte_address[1:0] == 2'b00) &&
                   (byte_address < ADDR_LIMIT);
    reject_p0    = vld_p0 && !term_p0 && !accept_p0;
    start_p0     = vld_p0 && (state != LOAD);
    timeout_p0   = (state == LOAD) && !vld_p0 &&
                   (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1));
    hold_done_p0 = (state == HOLD) && (hold_cnt == HOLD_W'(RELEASE_DELAY - 1));
  end

  always_comb begin
    state_nxt = state;
    if (vld_p0) begin
      // Any word, from any state, (re)enters the load; a word beats a pending timeout.
      state_nxt = term_p0 ? HOLD : LOAD;
    end else begin
      case (state)
        LOAD:    if (timeout_p0) state_nxt = HOLD;
        HOLD:    if (hold_done_p0) state_nxt = RUN;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      idle_cnt <= '0;
      hold_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (vld_p0)
        idle_cnt <= '0;
      else if (state == LOAD)
        idle_cnt <= idle_cnt + IDLE_W'(1);
      hold_cnt <= (state == HOLD && !vld_p0) ? hold_cnt + HOLD_W'(1) : '0;
    end
  end

  // Stage p1: registered write port and load statistics
  always_ff @(posedge clk) begin
    if (reset) begin
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      word_count <= '0;
      addr_error <= 1'b0;
    end else begin
      imem_we <= accept_p0;
      if (accept_p0) begin
        imem_addr  <= byte_address[ADDR_W+1:2];
        imem_wdata <= instruction_word;
      end
      if (start_p0) begin
        word_count <= accept_p0 ? 16'd1 : 16'd0;
        addr_error <= reject_p0;
      end else begin
        if (accept_p0) word_count <= sat_inc16(word_count);
        if (reject_p0) addr_error <= 1'b1;
      end
    end
  end

`ifdef BOOT_LOADER_CHECKSUM_EN
  logic [31:0] checksum_p1;

  always_ff @(posedge clk) begin
    if (reset) begin
      checksum_p1 <= '0;
    end else if (start_p0) begin
      checksum_p1 <= accept_p0 ? instruction_word : 32'd0;
    end else if (accept_p0) begin
      checksum_p1 <= checksum_p1 + instruction_word;
    end
  end

  assign checksum = checksum_p1;
`else
  assign checksum = 32'd0;
`endif

  assign cpu_reset = (state != RUN);
  assign load_done = (state == RUN);

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Directed self-checking bench for boot_loader_ctrl (TIMEOUT_CYCLES=100, RELEASE_DELAY=16).
module tb_boot_loader_ctrl;

  localparam int ADDR_W = 10;
`ifdef BOOT_LOADER_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              word_valid = 1'b0;
  logic [31:0]       instruction_word = '0;
  logic [31:0]       byte_address = '0;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_reset;
  logic              load_done;
  logic              addr_error;
  logic [15:0]       word_count;
  logic [31:0]       checksum;

  int n_checks = 0;
  int n_fail   = 0;

  boot_loader_ctrl #(
    .MEM_WORDS(1024), .ADDR_W(ADDR_W), .TIMEOUT_CYCLES(100), .RELEASE_DELAY(16)
  ) dut (
    .clk(clk), .reset(reset), .word_valid(word_valid),
    .instruction_word(instruction_word), .byte_address(byte_address),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_reset(cpu_reset), .load_done(load_done), .addr_error(addr_error),
    .word_count(word_count), .checksum(checksum)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Strobe one word in the current cycle; returns 1 time unit after the sampling edge.
  task automatic send(input logic [31:0] w, input logic [31:0] a);
    word_valid = 1'b1; instruction_word = w; byte_address = a;
    @(posedge clk); #1;
    word_valid = 1'b0; instruction_word = '0; byte_address = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(2);
    n_checks++; if (imem_we !== 1'b0) begin n_fail++; $display("FAIL rst_we got=%0h exp=0", imem_we); end
    n_checks++; if (imem_addr !== '0) begin n_fail++; $display("FAIL rst_addr got=%0h exp=0", imem_addr); end
    n_checks++; if (imem_wdata !== 32'd0) begin n_fail++; $display("FAIL rst_wdata got=%0h exp=0", imem_wdata); end
    n_checks++; if (cpu_reset !== 1'b1) begin n_fail++; $display("FAIL rst_cpu_reset got=%0h exp=1", cpu_reset); end
    n_checks++; if (load_done !== 1'b0) begin n_fail++; $display("FAIL rst_load_done got=%0h exp=0", load_done); end
    n_checks++; if (addr_error !== 1'b0) begin n_fail++; $display("FAIL rst_addr_error got=%0h exp=0", addr_error); end
    n_checks++; if (word_count !== 16'd0) begin n_fail++; $display("FAIL rst_count got=%0h exp=0", word_count); end
    n_checks++; if (checksum !== 32'd0) begin n_fail++; $display("FAIL rst_checksum got=%0h exp=0", checksum); end
    reset = 1'b0;
    // IDLE never releases the core without a load
    tick(30);
    n_checks++; if (cpu_reset !== 1'b1) begin n_fail++; $display("FAIL idle_hold got=%0h exp=1", cpu_reset); end
  endtask

  task automatic test_basic_load();
    do_reset();
    send(32'h0040_0093, 32'h0);
    n_checks++; if (imem_we !== 1'b1) begin n_fail++; $display("FAIL basic_we0 got=%0h exp=1", imem_we); end
    n_checks++; if (imem_addr !== 10'd0) begin n_fail++; $display("FAIL basic_addr0 got=%0h exp=0", imem_addr); end
    n_checks++; if (imem_wdata !== 32'h0040_0093) begin n_fail++; $display("FAIL basic_data0 got=%0h exp=00400093", imem_wdata); end
    n_checks++; if (word_count !== 16'd1) begin n_fail++; $display("FAIL basic_count0 got=%0h exp=1", word_count); end
    send(32'h0080_0113, 32'h4);
    n_checks++; if (imem_we !== 1'b1) begin n_fail++; $display("FAIL basic_we1 got=%0h exp=1", imem_we); end
    n_checks++; if (imem_addr !== 10'd1) begin n_fail++; $display("FAIL basic_addr1 got=%0h exp=1", imem_addr); end
    n_checks++; if (imem_wdata !== 32'h0080_0113) begin n_fail++; $display("FAIL basic_data1 got=%0h exp=00800113", imem_wdata); end
    n_checks++; if (word_count !== 16'd2) begin n_fail++; $display("FAIL basic_count got=%0h exp=2", word_count); end
    n_checks++; if (checksum !== (CK_EN ? 32'h00C0_01A6 : 32'd0)) begin n_fail++; $display("FAIL basic_checksum got=%0h exp=%0h", checksum, CK_EN ? 32'h00C0_01A6 : 32'd0); end
    send(32'hFFFF_FFFF, 32'h8);
    n_checks++; if (imem_we !== 1'b0) begin n_fail++; $display("FAIL term_no_write got=%0h exp=0", imem_we); end
    n_checks++; if (word_count !== 16'd2) begin n_fail++; $display("FAIL term_count got=%0h exp=2", word_count); end
    tick(15);
    n_checks++; if (cpu_reset !== 1'b1) begin n_fail++; $display("FAIL release_early got=%0h exp=1", cpu_reset); end
    tick(1);
    n_checks++; if (cpu_reset !== 1'b0) begin n_fail++; $display("FAIL release_at17 got=%0h exp=0", cpu_reset); end
    n_checks++; if (load_done !== 1'b1) begin n_fail++; $display("FAIL release_done got=%0h exp=1", load_done); end
  endtask

  task automatic test_reload();
    // Follows test_basic_load, so the core is running
    send(32'hDEAD_BEEF, 32'h0);
    n_checks++; if (cpu_reset !== 1'b1) begin n_fail++; $display("FAIL reload_cpu_reset got=%0h exp=1", cpu_reset); end
    n_checks++; if (load_done !== 1'b0) begin n_fail++; $display("FAIL reload_done got=%0h exp=0", load_done); end
    n_checks++; if (imem_we !== 1'b1 || imem_addr !== 10'd0) begin n_fail++; $display("FAIL reload_write got=%0h/%0h exp=1/0", imem_we, imem_addr); end
    n_checks++; if (imem_wdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL reload_data got=%0h exp=deadbeef", imem_wdata); end
    n_checks++; if (word_count !== 16'd1) begin n_fail++; $display("FAIL reload_count got=%0h exp=1", word_count); end
    n_checks++; if (checksum !== (CK_EN ? 32'hDEAD_BEEF : 32'd0)) begin n_fail++; $display("FAIL reload_checksum got=%0h exp=%0h", checksum, CK_EN ? 32'hDEAD_BEEF : 32'd0); end
    send(32'hFFFF_FFFF, 32'h0);
    tick(16);
    n_checks++; if (load_done !== 1'b1) begin n_fail++; $display("FAIL reload_release got=%0h exp=1", load_done); end
  endtask

  task automatic test_rejection();
    // Starts from RUN: the misaligned word restarts the load and flags the error
    send(32'h1234_5678, 32'h6);
    n_checks++; if (imem_we !== 1'b0) begin n_fail++; $display("FAIL rej_misalign_we got=%0h exp=0", imem_we); end
    n_checks++; if (addr_error !== 1'b1) begin n_fail++; $display("FAIL rej_misalign_err got=%0h exp=1", addr_error); end
    n_checks++; if (cpu_reset !== 1'b1) begin n_fail++; $display("FAIL rej_cpu_reset got=%0h exp=1", cpu_reset); end
    send(32'h1234_5678, 32'h1000);
    n_checks++; if (imem_we !== 1'b0) begin n_fail++; $display("FAIL rej_range_we got=%0h exp=0", imem_we); end
    n_checks++; if (word_count !== 16'd0) begin n_fail++; $display("FAIL rej_range_count got=%0h exp=0", word_count); end
    send(32'h0000_AAAA, 32'h8);
    n_checks++; if (imem_we !== 1'b1 || imem_addr !== 10'd2) begin n_fail++; $display("FAIL rej_valid_write got=%0h/%0h exp=1/2", imem_we, imem_addr); end
    n_checks++; if (addr_error !== 1'b1) begin n_fail++; $display("FAIL rej_sticky got=%0h exp=1", addr_error); end
    n_checks++; if (checksum !== (CK_EN ? 32'h0000_AAAA : 32'd0)) begin n_fail++; $display("FAIL rej_checksum got=%0h exp=%0h", checksum, CK_EN ? 32'h0000_AAAA : 32'd0); end
    send(32'h0000_5555, 32'hFFC);
    n_checks++; if (imem_we !== 1'b1 || imem_addr !== 10'h3FF) begin n_fail++; $display("FAIL rej_top_word got=%0h/%0h exp=1/3ff", imem_we, imem_addr); end
    n_checks++; if (word_count !== 16'd2) begin n_fail++; $display("FAIL rej_top_count got=%0h exp=2", word_count); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] words [3];
    words[0] = 32'h1111_0001; words[1] = 32'h2222_0002; words[2] = 32'h3333_0003;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      word_valid = 1'b1; instruction_word = words[i]; byte_address = 32'(16 + 4 * i);
      @(posedge clk); #1;
      n_checks++; if (imem_we !== 1'b1 || imem_addr !== 10'(4 + i) || imem_wdata !== words[i]) begin
        n_fail++; $display("FAIL b2b_write%0d got=%0h/%0h/%0h exp=1/%0h/%0h", i, imem_we, imem_addr, imem_wdata, 4 + i, words[i]);
      end
    end
    word_valid = 1'b0;
    n_checks++; if (word_count !== 16'd3) begin n_fail++; $display("FAIL b2b_count got=%0h exp=3", word_count); end
    tick(1);
    n_checks++; if (imem_we !== 1'b0) begin n_fail++; $display("FAIL b2b_single_pulse got=%0h exp=0", imem_we); end
  endtask

  task automatic test_timeout();
    do_reset();
    send(32'h0000_0013, 32'h0);
    tick(115);
    n_checks++; if (cpu_reset !== 1'b1) begin n_fail++; $display("FAIL timeout_early got=%0h exp=1", cpu_reset); end
    tick(1);
    n_checks++; if (cpu_reset !== 1'b0 || load_done !== 1'b1) begin n_fail++; $display("FAIL timeout_run got=%0h/%0h exp=0/1", cpu_reset, load_done); end
    // A word landing on the expiry cycle keeps the load open
    do_reset();
    send(32'h0000_0013, 32'h0);
    tick(99);
    send(32'h0000_0033, 32'h4);
    n_checks++; if (imem_we !== 1'b1 || word_count !== 16'd2) begin n_fail++; $display("FAIL expiry_word got=%0h/%0h exp=1/2", imem_we, word_count); end
    tick(16);
    n_checks++; if (cpu_reset !== 1'b1) begin n_fail++; $display("FAIL expiry_no_release got=%0h exp=1", cpu_reset); end
    tick(99);
    n_checks++; if (cpu_reset !== 1'b1) begin n_fail++; $display("FAIL expiry_restart_early got=%0h exp=1", cpu_reset); end
    tick(1);
    n_checks++; if (cpu_reset !== 1'b0) begin n_fail++; $display("FAIL expiry_restart_run got=%0h exp=0", cpu_reset); end
  endtask

  task automatic test_reset_mid_load();
    do_reset();
    send(32'h0000_0093, 32'h0);
    send(32'h0000_0113, 32'h4);
    reset = 1'b1;
    tick(1);
    n_checks++; if (imem_we !== 1'b0 || imem_addr !== '0 || imem_wdata !== 32'd0) begin n_fail++; $display("FAIL midrst_port got=%0h/%0h/%0h exp=0/0/0", imem_we, imem_addr, imem_wdata); end
    n_checks++; if (word_count !== 16'd0 || checksum !== 32'd0 || addr_error !== 1'b0) begin n_fail++; $display("FAIL midrst_stats got=%0h/%0h/%0h exp=0/0/0", word_count, checksum, addr_error); end
    n_checks++; if (cpu_reset !== 1'b1 || load_done !== 1'b0) begin n_fail++; $display("FAIL midrst_ctrl got=%0h/%0h exp=1/0", cpu_reset, load_done); end
    reset = 1'b0;
    // IDLE, not LOAD: no timeout release follows
    tick(130);
    n_checks++; if (cpu_reset !== 1'b1) begin n_fail++; $display("FAIL midrst_idle got=%0h exp=1", cpu_reset); end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_reload();
    test_rejection();
    test_back_to_back();
    test_timeout();
    test_reset_mid_load();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/boot_loader_ctrl.md
# boot_loader_ctrl

Sequences program download into instruction memory. Sits between the UART word decoder and the instruction-memory write port, holding the core in reset while words are loaded. It releases the core once the load terminates. It validates each decoded word's address, counts loaded words and supports re-loading at any time.

## Interface

Parameters:
- `MEM_WORDS`, 1024: instruction-memory depth in 32-bit words.
- `ADDR_W`, 10: imem word-address width; must satisfy 2^ADDR_W >= MEM_WORDS.
- `TIMEOUT_CYCLES`, 1_000_000: idle cycles after the last word that end a load.
- `RELEASE_DELAY`, 16: cycles between end of load and `cpu_reset` deassertion; must be >= 1.

Ports:
- `clk`  in  1  sole clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `word_valid`  in  1  single-cycle strobe from the decoder; a new word is present.
- `instruction_word`  in  32  decoded word; valid when `word_valid`=1.
- `byte_address`  in  32  decoded byte address; valid when `word_valid`=1.
- `imem_we`  out  1  imem write enable; 1-cycle pulse.
- `imem_addr`  out  ADDR_W  imem word address (`byte_address[ADDR_W+1:2]`).
- `imem_wdata`  out  32  imem write data.
- `cpu_reset`  out  1  active-high core reset hold.
- `load_done`  out  1  1 in RUN state.
- `addr_error`  out  1  sticky; a word was rejected during the current/last load.
- `word_count`  out  16  words written in the current/last load; saturates at 0xFFFF.
- `checksum`  out  32  running sum of written words (see Configuration).

## Operation

- States: IDLE, LOAD, HOLD, RUN.
- IDLE, entered on reset:
  - `cpu_reset`=1.
  - The first `word_valid` goes to LOAD and is processed as a load word.
- Load start (entry to LOAD from IDLE or RUN):
  - Clear `word_count`, `addr_error` and `checksum` in the same cycle.
  - Process the triggering word.
- Word processing in LOAD:
  - Terminator: `instruction_word`==0xFFFFFFFF.
    - Not written and not counted.
    - Go to HOLD.
  - Accepted word, which requires both:
    - `byte_address[1:0]`==0;
    - `byte_address` < MEM_WORDS*4.
  - Any other non-terminator word is rejected: no write, `addr_error`←1.
  - Each accepted word:
    - one imem write;
    - `word_count`+1, saturating;
    - `checksum`+word, mod 2^32.
- Timeout in LOAD:
  - An idle counter resets on every `word_valid`.
  - It increments otherwise.
  - Reaching TIMEOUT_CYCLES goes to HOLD.
- HOLD:
  - Counts RELEASE_DELAY cycles, then goes to RUN.
  - `word_valid` during HOLD restarts the load: go to LOAD, clear statistics, process the word.
- RUN:
  - `cpu_reset`=0, `load_done`=1.
  - `word_valid` restarts the load: `cpu_reset`←1 next cycle, state LOAD.
- Simultaneous events:
  - `word_valid` in the cycle the timeout would expire: the word wins; it is processed and the counter clears.
  - A terminator wins over a timeout.
- Reset mid-operation: all state returns to IDLE with reset values; no partial write is issued after reset.

## Timing

- Reset values:
  - `imem_we`=0, `imem_addr`=0, `imem_wdata`=0.
  - `cpu_reset`=1, `load_done`=0, `addr_error`=0.
  - `word_count`=0, `checksum`=0.
- Write latency: `word_valid` at cycle N gives `imem_we`=1 with registered addr/data at cycle N+1, for exactly one cycle.
- `word_count` and `checksum` update at N+1.
- `addr_error` rises at N+1.
- Terminator at cycle N:
  - state=HOLD at N+1;
  - `cpu_reset`=0 and `load_done`=1 at N+1+RELEASE_DELAY.
- Timeout: with the last word at cycle N, state=HOLD at N+1+TIMEOUT_CYCLES.
- Restart from RUN: `word_valid` at N gives `cpu_reset`=1 and `load_done`=0 at N+1.
- Back-to-back `word_valid` on consecutive cycles is supported; one write per strobe.

## Configuration

- `BOOT_LOADER_CHECKSUM_EN` defined: `checksum` accumulates as described.
- Not defined:
  - `checksum` is tied to 0.
  - The adder and its register are absent.
  - All other behaviour is identical.

## Test plan

- Basic load, MEM_WORDS=1024, RELEASE_DELAY=16:
  - Stimulus: 0x00400093@0x0, then 0x00800113@0x4, then terminator.
  - Writes: addr 0/0x00400093 and addr 1/0x00800113.
  - Counters: `word_count`=2, `checksum`=0x00C001A6.
  - Release: `cpu_reset` falls exactly 17 cycles after the terminator strobe.
- Rejection:
  - 0x12345678@0x6 → no `imem_we`, `addr_error`=1.
  - Then 0x12345678@0x1000 → no write, `word_count`=0.
  - Then a valid word@0x8 → written to addr 2, `addr_error` stays 1.
- Timeout, TIMEOUT_CYCLES=100:
  - One word@0x0, then silence → HOLD exactly 101 cycles after the strobe, RUN 16 cycles later.
  - A word at the expiry cycle prevents the transition.
- Reload from RUN:
  - After the basic load, 0xDEADBEEF@0x0 → `cpu_reset`=1 next cycle.
  - Counters cleared then updated: `word_count`=1, `checksum`=0xDEADBEEF.
  - The word is written to addr 0.
- Reset mid-load: assert `reset` the cycle after a `word_valid` → all outputs at reset values next cycle, state IDLE.
- Build without `BOOT_LOADER_CHECKSUM_EN`: repeat the basic load → `checksum`=0, everything else unchanged.
